writeback_unit: RTL

//  Registered writeback stage between the memory stage and the register file.
//  - ALU results: passed through to the register file write port.
//  - Loads: issues the memory address, waits any number of cycles for the

---
 rtl/writeback_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: ALU results reach the register file 1 cycle after accept; loads take 2+ cycles.
// ready_o drops while a load waits for memory, so upstream holds its instruction until the response.
module writeback_unit #(
  parameter int ADDR_SIZE     = 5,
  parameter int WORD_SIZE     = 32,
  parameter int REG_ADDR_SIZE = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [WORD_SIZE-1:0]     alu_data_i,
  input  logic                     load_i,
  input  logic [1:0]               size_i,
  input  logic                     unsigned_i,
  input  logic [REG_ADDR_SIZE-1:0] rd_addr_i,
  input  logic                     rd_we_i,
  output logic [ADDR_SIZE-1:0]     mem_addr_o,
  input  logic [WORD_SIZE-1:0]     mem_data_i,
  input  logic                     mem_valid_i,
  output logic                     rd_we_o,
  output logic [REG_ADDR_SIZE-1:0] rd_addr_o,
  output logic [WORD_SIZE-1:0]     rd_data_o
);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic [ADDR_SIZE-1:0]     addr;
    logic [1:0]               size;
    logic                     uns;
    logic [REG_ADDR_SIZE-1:0] rd;
    logic                     we;
  } ld_t;

  state_t                   state_q, state_d;
  ld_t                      ld_q, ld_d;
  logic                     rd_we_q, rd_we_d;
  logic [REG_ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [WORD_SIZE-1:0]     rd_data_q, rd_data_d;

  logic [1:0]           off;
  logic [7:0]           lane_b;
  logic [15:0]          lane_h;
  logic [WORD_SIZE-1:0] ld_data;

  assign ready_o    = !rst_i && (state_q == IDLE);
  assign mem_addr_o = rst_i ? '0 :
                      (state_q == IDLE) ? alu_data_i[ADDR_SIZE-1:0] : ld_q.addr;
  assign rd_we_o    = rd_we_q;
  assign rd_addr_o  = rd_addr_q;
  assign rd_data_o  = rd_data_q;

  // Little-endian lane select; halfword ignores off[0] rather than trapping.
  always_comb begin
    off = ld_q.addr[1:0];
    case (off)
      2'd0:    lane_b = mem_data_i[7:0];
      2'd1:    lane_b = mem_data_i[15:8];
      2'd2:    lane_b = mem_data_i[23:16];
      default: lane_b = mem_data_i[31:24];
    endcase
    lane_h = off[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    case (ld_q.size)
      2'b00:   ld_data = {{(WORD_SIZE-8){~ld_q.uns & lane_b[7]}}, lane_b};
      2'b01:   ld_data = {{(WORD_SIZE-16){~ld_q.uns & lane_h[15]}}, lane_h};
      default: ld_data = mem_data_i;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ld_d      = ld_q;
    rd_we_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (load_i) begin
            ld_d.addr = alu_data_i[ADDR_SIZE-1:0];
            ld_d.size = size_i;
            ld_d.uns  = unsigned_i;
            ld_d.rd   = rd_addr_i;
            ld_d.we   = rd_we_i;
            state_d   = WAIT;
          end else begin
            rd_we_d   = rd_we_i && (rd_addr_i != '0);
            rd_addr_d = rd_addr_i;
            rd_data_d = alu_data_i;
          end
        end
      end
      default: begin
        // Response is only honoured here, so a load never completes in its accept cycle.
        if (mem_valid_i) begin
          rd_we_d   = ld_q.we && (ld_q.rd != '0);
          rd_addr_d = ld_q.rd;
          rd_data_d = ld_data;
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ld_q      <= '0;
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_q      <= ld_d;
      rd_we_q   <= rd_we_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule
